// File: rtl/sccb_responder_pkg.sv
// Shared types for the SCCB responder.
// Contents: state_t (responder FSM states) and SCCB_BITS_PER_PHASE
// (eight payload bits plus one don't-care/ACK bit per phase).
package sccb_pkg;
    localparam int SCCB_BITS_PER_PHASE = 9;

    typedef enum logic [3:0] {
        IDLE,
        ID,
        ID_DC,
        SUB,
        SUB_DC,
        WDATA,
        WDATA_DC,
        RDATA,
        RDATA_NA,
        IGNORE
    } state_t;
endpackage

// File: rtl/sccb_responder_if.sv
// Bus bundle between the SCCB responder and whatever sits around it
// (pads on one side, register file on the other).
// Signals:
//   sioc, siod_i   SCCB clock / data as seen on the pads
//   siod_oe        1 = responder pulls SIOD low
//   reg_addr       current sub-address
//   wr_en, wr_data one-cycle write strobe and its data
//   rd_data        register contents at reg_addr
//   rd_strobe      one-cycle pulse when rd_data is latched
//   busy           high from START until the following STOP
// Modports: slave = the responder, master = its environment.
interface sccb_responder_if;
    logic       sioc;
    logic       siod_i;
    logic       siod_oe;
    logic [7:0] reg_addr;
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_strobe;
    logic       busy;

    modport slave (
        input  sioc, siod_i, rd_data,
        output siod_oe, reg_addr, wr_en, wr_data, rd_strobe, busy
    );

    modport master (
        output sioc, siod_i, rd_data,
        input  siod_oe, reg_addr, wr_en, wr_data, rd_strobe, busy
    );
endinterface

// File: rtl/sccb_responder_line_sync.sv
// Synchronizes SIOC/SIOD into the system clock domain and decodes
// SIOC edges plus START/STOP conditions from the synchronized values.
// Ports:
//   clk, resetn  system clock, async active-low reset
//   sioc, siod   raw pad inputs
//   siod_s       synchronized SIOD (for bit sampling)
//   rise, fall   one-cycle SIOC edge pulses
//   start, stop  one-cycle START / STOP condition pulses
// SYNC_STAGES: legal range 2..3.
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic sioc,
    input  logic siod,
    output logic siod_s,
    output logic rise,
    output logic fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] sioc_ff, siod_ff;
    logic sioc_s, sioc_p, siod_p;

    // Reset to the idle-bus level (both lines high) so leaving reset
    // never looks like an edge or a START.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sioc_ff <= '1;
            siod_ff <= '1;
            sioc_p  <= 1'b1;
            siod_p  <= 1'b1;
        end else begin
            sioc_ff <= {sioc_ff[SYNC_STAGES-2:0], sioc};
            siod_ff <= {siod_ff[SYNC_STAGES-2:0], siod};
            sioc_p  <= sioc_s;
            siod_p  <= siod_s;
        end
    end

    assign sioc_s = sioc_ff[SYNC_STAGES-1];
    assign siod_s = siod_ff[SYNC_STAGES-1];
    assign rise   = sioc_s & ~sioc_p;
    assign fall   = ~sioc_s & sioc_p;
    assign start  = sioc_s & siod_p & ~siod_s;
    assign stop   = sioc_s & ~siod_p & siod_s;
endmodule

// File: rtl/sccb_responder.sv
// SCCB target model: decodes ID / sub-address / data phases from an
// oversampled SIOC/SIOD pair, presents 3-phase writes and 2-phase reads
// on a simple register port, and drives SIOD open-drain for read data.
// Ports:
//   clk, resetn  system clock (>= 8x SCCB bit rate), async active-low reset
//   bus          sccb_responder_if.slave (pads + register port)
// Optional build macro SCCB_RESP_AUTOINC_EN: auto-increment of reg_addr
// after each write/read plus burst writes and ACK-continued burst reads.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID      = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            resetn,
    sccb_responder_if.slave bus
);
    logic rise, fall, start, stop, siod_s;

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .sioc   (bus.sioc),
        .siod   (bus.siod_i),
        .siod_s (siod_s),
        .rise   (rise),
        .fall   (fall),
        .start  (start),
        .stop   (stop)
    );

    state_t     state;
    logic [2:0] cnt;
    logic [7:0] shreg, shifted;
    logic       is_read;
    logic       siod_oe, wr_en, rd_strobe, busy;
    logic [7:0] reg_addr, wr_data;
`ifdef SCCB_RESP_AUTOINC_EN
    logic       ack;
`endif

    assign shifted = {shreg[6:0], siod_s};

    // In the *_DC / RDATA_NA states cnt is reused as a "9th rise still
    // pending" flag: entered at 1, cleared on the rise, acted on at the
    // fall that follows it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            is_read   <= 1'b0;
            siod_oe   <= 1'b0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            reg_addr  <= '0;
            rd_strobe <= 1'b0;
            busy      <= 1'b0;
`ifdef SCCB_RESP_AUTOINC_EN
            ack       <= 1'b0;
`endif
        end else begin
            wr_en     <= 1'b0;
            rd_strobe <= 1'b0;
`ifdef SCCB_RESP_AUTOINC_EN
            if (wr_en) reg_addr <= reg_addr + 8'd1;
`endif
            if (stop) begin
                state   <= IDLE;
                siod_oe <= 1'b0;
                busy    <= 1'b0;
            end else if (start) begin
                state   <= ID;
                cnt     <= 3'd7;
                busy    <= 1'b1;
                siod_oe <= 1'b0;
            end else begin
                case (state)
                    ID, SUB, WDATA: if (rise) begin
                        shreg <= shifted;
                        cnt   <= cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            cnt <= 3'd1;
                            case (state)
                                ID: if (shifted[7:1] != DEV_ID) state <= IGNORE;
                                    else begin
                                        is_read <= shifted[0];
                                        state   <= ID_DC;
                                    end
                                SUB: begin
                                    reg_addr <= shifted;
                                    state    <= SUB_DC;
                                end
                                default: begin
                                    wr_data <= shifted;
                                    wr_en   <= 1'b1;
                                    state   <= WDATA_DC;
                                end
                            endcase
                        end
                    end
                    ID_DC, SUB_DC, WDATA_DC: begin
                        if (rise) cnt <= 3'd0;
                        else if (fall && cnt == 3'd0) begin
                            cnt <= 3'd7;
                            case (state)
                                ID_DC: if (is_read) begin
                                    // Latch the byte once; later rd_data changes are ignored.
                                    shreg     <= bus.rd_data;
                                    rd_strobe <= 1'b1;
                                    siod_oe   <= ~bus.rd_data[7];
                                    state     <= RDATA;
`ifdef SCCB_RESP_AUTOINC_EN
                                    reg_addr  <= reg_addr + 8'd1;
`endif
                                end else state <= SUB;
                                SUB_DC: state <= WDATA;
`ifdef SCCB_RESP_AUTOINC_EN
                                default: state <= WDATA;
`else
                                default: state <= WDATA_DC;
`endif
                            endcase
                        end
                    end
                    RDATA: if (fall) begin
                        if (cnt == 3'd0) begin
                            siod_oe <= 1'b0;
                            cnt     <= 3'd1;
                            state   <= RDATA_NA;
                        end else begin
                            cnt     <= cnt - 3'd1;
                            shreg   <= shreg << 1;
                            siod_oe <= ~shreg[6];
                        end
                    end
`ifdef SCCB_RESP_AUTOINC_EN
                    RDATA_NA: begin
                        if (rise) begin
                            cnt <= 3'd0;
                            ack <= ~siod_s;
                        end else if (fall && cnt == 3'd0 && ack) begin
                            shreg     <= bus.rd_data;
                            rd_strobe <= 1'b1;
                            siod_oe   <= ~bus.rd_data[7];
                            reg_addr  <= reg_addr + 8'd1;
                            cnt       <= 3'd7;
                            state     <= RDATA;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.siod_oe   = siod_oe;
    assign bus.reg_addr  = reg_addr;
    assign bus.wr_en     = wr_en;
    assign bus.wr_data   = wr_data;
    assign bus.rd_strobe = rd_strobe;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: a bit-banged SCCB master drives directed
// transactions; expected writes and read strobes go into queues that a
// monitor pops whenever the DUT strobes wr_en / rd_strobe.
module tb_sccb_responder;
    import sccb_pkg::*;

`ifdef SCCB_RESP_AUTOINC_EN
    localparam bit AI = 1'b1;
`else
    localparam bit AI = 1'b0;
`endif

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0, resetn = 1'b0, sda = 1'b1, oe_allowed = 1'b0;
    int   checks = 0, failures = 0, oe_viol = 0;
    wr_t  wr_q[$];
    logic [7:0] rd_q[$];

    always #5 clk = ~clk;

    sccb_responder_if bus();
    assign bus.siod_i = sda & ~bus.siod_oe;   // open-drain wired-AND with pull-up

    sccb_responder #(.DEV_ID(7'h21), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every DUT strobe against the scoreboard queues.
    always @(negedge clk) begin
        if (bus.siod_oe && !oe_allowed) oe_viol++;
        if (resetn && bus.wr_en) begin
            if (wr_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL wr_unexpected actual addr=%0h data=%0h required=none",
                         bus.reg_addr, bus.wr_data);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_addr", bus.reg_addr, e.addr);
                check("wr_data", bus.wr_data, e.data);
            end
        end
        if (resetn && bus.rd_strobe) begin
            if (rd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_unexpected actual addr=%0h required=none", bus.reg_addr);
            end else check("rd_addr", bus.reg_addr, rd_q.pop_front());
        end
    end

    task automatic wait_q();
        repeat (4) @(negedge clk);
    endtask

    task automatic m_start();
        sda = 1'b1; wait_q();
        bus.sioc = 1'b1; wait_q();
        sda = 1'b0; wait_q();
        bus.sioc = 1'b0; wait_q();
    endtask

    task automatic m_stop();
        sda = 1'b0; wait_q();
        bus.sioc = 1'b1; wait_q();
        sda = 1'b1; wait_q();
        repeat (3) @(negedge clk);
    endtask

    task automatic m_bit(input logic b, output logic r);
        sda = b; wait_q();
        bus.sioc = 1'b1; wait_q();
        r = bus.siod_i; wait_q();
        bus.sioc = 1'b0; wait_q();
    endtask

    // Eight data bits MSB-first followed by the released 9th bit.
    task automatic m_byte(input logic [7:0] b, output logic [7:0] r);
        logic x;
        for (int i = 7; i >= 0; i--) m_bit(b[i], r[i]);
        m_bit(1'b1, x);
    endtask

    initial begin
        logic [7:0] r, exp_addr;
        logic x;
        bus.sioc = 1'b1;
        bus.rd_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_siod_oe", bus.siod_oe, 8'h0);
        check("rst_wr_en", bus.wr_en, 8'h0);
        check("rst_wr_data", bus.wr_data, 8'h0);
        check("rst_reg_addr", bus.reg_addr, 8'h0);
        check("rst_rd_strobe", bus.rd_strobe, 8'h0);
        check("rst_busy", bus.busy, 8'h0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // 3-phase write 0x42 / 0x12 / 0x80
        wr_q.push_back('{8'h12, 8'h80});
        m_start();
        check("busy_after_start", bus.busy, 8'h1);
        m_byte(8'h42, r); m_byte(8'h12, r); m_byte(8'h80, r);
        m_stop();
        check("busy_after_stop", bus.busy, 8'h0);
        exp_addr = AI ? 8'h13 : 8'h12;
        check("addr_after_write", bus.reg_addr, exp_addr);

        // 2-phase write sets sub 0x0A, then 2-phase read
        m_start(); m_byte(8'h42, r); m_byte(8'h0A, r); m_stop();
        check("addr_2phase", bus.reg_addr, 8'h0A);
        bus.rd_data = 8'h76;
        rd_q.push_back(AI ? 8'h0B : 8'h0A);   // observed after any increment
        oe_allowed = 1'b1;
        m_start(); m_byte(8'h43, r);
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, r[i]);
            if (i == 6) bus.rd_data = 8'h00;  // must not disturb the latched byte
        end
        m_bit(1'b1, x);                        // master NA
        check("read_byte", r, 8'h76);
        check("oe_released_na", bus.siod_oe, 8'h0);
        oe_allowed = 1'b0;
        m_stop();
        exp_addr = AI ? 8'h0B : 8'h0A;
        check("addr_after_read", bus.reg_addr, exp_addr);

        // Foreign ID: nothing written, busy held until STOP
        m_start(); m_byte(8'h60, r); m_byte(8'h12, r); m_byte(8'h34, r);
        check("busy_ignore", bus.busy, 8'h1);
        m_stop();
        check("busy_ignore_stop", bus.busy, 8'h0);
        check("addr_ignore", bus.reg_addr, exp_addr);

        // Repeated START after 4 data bits aborts the write
        m_start(); m_byte(8'h42, r); m_byte(8'h55, r);
        for (int i = 0; i < 4; i++) m_bit(1'b1, x);
        wr_q.push_back('{8'h3A, 8'h04});
        m_start(); m_byte(8'h42, r); m_byte(8'h3A, r); m_byte(8'h04, r);
        m_stop();
        exp_addr = AI ? 8'h3B : 8'h3A;
        check("addr_after_restart", bus.reg_addr, exp_addr);

`ifdef SCCB_RESP_AUTOINC_EN
        // Burst write wraps 0xFF -> 0x00
        wr_q.push_back('{8'hFF, 8'h11});
        wr_q.push_back('{8'h00, 8'h22});
        m_start(); m_byte(8'h42, r); m_byte(8'hFF, r);
        m_byte(8'h11, r); m_byte(8'h22, r);
        m_stop();
        exp_addr = 8'h01;
        check("addr_after_burst", bus.reg_addr, exp_addr);
`endif

        // Reset while driving a 0 bit releases SIOD without a clock edge
        bus.rd_data = 8'h00;
        rd_q.push_back(AI ? exp_addr + 8'd1 : exp_addr);
        oe_allowed = 1'b1;
        m_start(); m_byte(8'h43, r);
        repeat (2) @(negedge clk);
        check("oe_before_reset", bus.siod_oe, 8'h1);
        #2 resetn = 1'b0;
        #1;
        check("oe_async_reset", bus.siod_oe, 8'h0);
        check("busy_async_reset", bus.busy, 8'h0);
        check("state_async_reset", {4'h0, dut.state}, {4'h0, IDLE});
        oe_allowed = 1'b0;
        sda = 1'b1;
        bus.sioc = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("addr_after_reset", bus.reg_addr, 8'h0);

        check("wr_q_drained", 8'(wr_q.size()), 8'h0);
        check("rd_q_drained", 8'(rd_q.size()), 8'h0);
        check("oe_outside_read", 8'(oe_viol), 8'h0);
        check("phase_bits", 8'(SCCB_BITS_PER_PHASE), 8'd9);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
